sm_trace_buffer: RTL

Synthesizable execution-trace recorder for the sm_cpu core. Each enabled CPU cycle it captures the `{pc, instr}` pair into a DEPTH-entry buffer, counts cycles, and freezes on buffer-full, cycle timeout or an external stop. This replaces the simulation-only per-cycle printout and timeout check. The buffer is drained through a registered read port, so it works both in simulation and on the board.

---
 rtl/sm_trace_pkg.sv | 16 +
 rtl/sm_trace_ram.sv | 40 ++++
 rtl/sm_trace_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sm_trace_pkg.sv
// sm_trace_pkg: definitions shared by the sm_cpu trace recorder.
//   ENTRY_W      width of one trace entry, {pc, instr}
//   traceState_t recorder state codes as seen on the 'state' output
//                (ST_WAIT is only reachable when SM_TRACE_TRIGGER_EN is defined)
package sm_trace_pkg;

   localparam int ENTRY_W = 64;

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2,
      ST_WAIT   = 2'd3
   } traceState_t;

endpackage

// File: rtl/sm_trace_ram.sv
// sm_trace_ram: DEPTH x DATA_W simple dual-port trace memory.
//   clk     clock
//   wrEn    write strobe; wrData is stored at wrAddr on the rising edge
//   wrAddr  write address
//   wrData  write data
//   rdEn    read strobe; mem[rdAddr] is registered into rdData
//   rdAddr  read address
//   rdData  registered read data (holds its value while rdEn is low)
// The contents and the read register are deliberately not reset so the
// array maps onto block RAM. A read and a write to the same address in one
// cycle return the old contents (read-first), which the recorder relies on
// when it pops the oldest entry of a full buffer while overwriting it.
module sm_trace_ram
   import sm_trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = ENTRY_W
) (
   input  logic              clk,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              rdEn,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
      if (rdEn) begin
         rdData <= mem[rdAddr];
      end
   end

endmodule

// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: execution-trace recorder for the sm_cpu core.
// Captures {pc, instr} on every enabled CPU cycle while running, counts the
// captured cycles and freezes on buffer-full (non-circular mode), on the
// cycle timeout or on an external stop. Entries are drained oldest-first
// through a registered read port.
//   Parameters: DEPTH (power of 2, >= 2), TIMEOUT_CYCLES (0 = no timeout),
//               CNT_W (cycle counter width)
//   clk, rst_n        clock, asynchronous active-low reset
//   cpu_en, pc, instr capture strobe and the traced pair
//   start/stop/clear  control pulses (clear > stop > start)
//   circ              1 = overwrite oldest when full, 0 = freeze when full
//   trig_pc           trigger PC (trigger build only)
//   rd_en             pop request
//   rd_data/rd_valid  popped entry, one cycle after rd_en
//   count, cycles     valid entries, captured cycles since clear
//   state             0 ARMED, 1 RUN, 2 FROZEN, 3 WAIT
//   overflow/timeout  sticky flags
// Build option: define SM_TRACE_TRIGGER_EN to make 'start' wait in WAIT
// until a CPU cycle with pc == trig_pc, which then becomes entry 0.
module sm_trace_buffer
   import sm_trace_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 120,
   parameter int CNT_W          = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cpu_en,
   input  logic [31:0]            pc,
   input  logic [31:0]            instr,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   clear,
   input  logic                   circ,
   input  logic [31:0]            trig_pc,
   input  logic                   rd_en,
   output logic [ENTRY_W-1:0]     rd_data,
   output logic                   rd_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic [CNT_W-1:0]       cycles,
   output logic [1:0]             state,
   output logic                   overflow,
   output logic                   timeout
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CW     = ADDR_W + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   // A timeout value the counter can never hold would otherwise alias
   // after truncation, so it simply disables the timeout.
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0) &&
                          ((CNT_W >= 31) || (TIMEOUT_CYCLES < (1 << CNT_W)));

`ifdef SM_TRACE_TRIGGER_EN
   localparam traceState_t START_STATE = ST_WAIT;
`else
   localparam traceState_t START_STATE = ST_RUN;
`endif

   traceState_t        curState;
   logic [ADDR_W-1:0]  wrPtr;
   logic [ADDR_W-1:0]  rdPtr;
   logic [CW-1:0]      countReg;
   logic [CW-1:0]      countNext;
   logic [CNT_W-1:0]   cycleCnt;
   logic [CNT_W-1:0]   cycleInc;
   logic               ovfFlag;
   logic               toFlag;
   logic               rdValidReg;
   logic [ENTRY_W-1:0] ramRdData;

   logic trigHit;
   logic capture;
   logic isFull;
   logic doRead;
   logic overwrite;
   logic timeoutHit;
   logic fullFreeze;

`ifdef SM_TRACE_TRIGGER_EN
   assign trigHit = (curState == ST_WAIT) && (pc == trig_pc);
`else
   logic unusedTrigPc;
   assign trigHit      = 1'b0;
   assign unusedTrigPc = ^trig_pc;
`endif

   // stop and clear win over a capture in the same cycle.
   assign capture   = cpu_en && !clear && !stop && ((curState == ST_RUN) || trigHit);
   assign isFull    = (countReg == FULL_COUNT);
   assign doRead    = rd_en && !clear && (countReg != '0);
   // A simultaneous pop already frees the oldest slot, so only a write into
   // a full buffer without a pop loses data.
   assign overwrite = capture && isFull && !doRead;
   assign cycleInc  = (&cycleCnt) ? cycleCnt : cycleCnt + CNT_W'(1);

   always_comb begin
      countNext = countReg;
      if (capture && !doRead && !isFull) begin
         countNext = countReg + CW'(1);
      end else if (doRead && !capture) begin
         countNext = countReg - CW'(1);
      end
   end

   assign timeoutHit = capture && TO_EN && (cycleInc == CNT_W'(TIMEOUT_CYCLES));
   assign fullFreeze = capture && !circ && (countNext == FULL_COUNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState   <= ST_ARMED;
         wrPtr      <= '0;
         rdPtr      <= '0;
         countReg   <= '0;
         cycleCnt   <= '0;
         ovfFlag    <= 1'b0;
         toFlag     <= 1'b0;
         rdValidReg <= 1'b0;
      end else if (clear) begin
         curState   <= ST_ARMED;
         wrPtr      <= '0;
         rdPtr      <= '0;
         countReg   <= '0;
         cycleCnt   <= '0;
         ovfFlag    <= 1'b0;
         toFlag     <= 1'b0;
         rdValidReg <= 1'b0;
      end else begin
         if (capture) begin
            wrPtr    <= wrPtr + ADDR_W'(1);
            cycleCnt <= cycleInc;
         end
         if (doRead || overwrite) begin
            rdPtr <= rdPtr + ADDR_W'(1);
         end
         countReg   <= countNext;
         rdValidReg <= doRead;
         if (overwrite) begin
            ovfFlag <= 1'b1;
         end
         if (timeoutHit) begin
            toFlag <= 1'b1;
         end

         if (stop) begin
            curState <= ST_FROZEN;
         end else begin
            case (curState)
               ST_ARMED: begin
                  if (start) begin
                     curState <= START_STATE;
                  end
               end
               ST_RUN: begin
                  if (timeoutHit || fullFreeze) begin
                     curState <= ST_FROZEN;
                  end
               end
               ST_WAIT: begin
                  if (timeoutHit || fullFreeze) begin
                     curState <= ST_FROZEN;
                  end else if (capture) begin
                     curState <= ST_RUN;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   sm_trace_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (ENTRY_W)
   ) uRam (
      .clk    (clk),
      .wrEn   (capture),
      .wrAddr (wrPtr),
      .wrData ({pc, instr}),
      .rdEn   (doRead),
      .rdAddr (rdPtr),
      .rdData (ramRdData)
   );

   // The RAM output register has no reset; masking it keeps rd_data at zero
   // after reset and clear and whenever no pop is being presented.
   assign rd_data  = rdValidReg ? ramRdData : '0;
   assign rd_valid = rdValidReg;
   assign count    = countReg;
   assign cycles   = cycleCnt;
   assign state    = curState;
   assign overflow = ovfFlag;
   assign timeout  = toFlag;

endmodule
